// File: rtl/stereo_framer_pkg.sv
// rtl/stereo_framer_pkg.sv - shared framer constants: FSM encoding, sync byte, window depth
package stereo_framer_pkg;

    localparam logic [1:0] ST_HUNT  = 2'd0;
    localparam logic [1:0] ST_GET_L = 2'd1;
    localparam logic [1:0] ST_GET_R = 2'd2;

    localparam logic [7:0] DEFAULT_SYNC_BYTE = 8'hFF;

    localparam int WINDOW_DEPTH = 8;
    localparam int SAMPLE_W     = 8;
    localparam int WINDOW_W     = WINDOW_DEPTH * SAMPLE_W;

endpackage

// File: rtl/sample_window.sv
// rtl/sample_window.sv - 8-deep byte shift register with parallel window output
module sample_window
    import stereo_framer_pkg::*;
(
    input  logic                clk,
    input  logic                rst,
    input  logic                shift_en_i,
    input  logic [SAMPLE_W-1:0] sample_i,
    output logic [WINDOW_W-1:0] window_o
);

    logic [WINDOW_W-1:0] window_q;
    logic [WINDOW_W-1:0] window_d;

    // Newest sample enters the low byte; the oldest falls off the top.
    always_comb begin
        window_d = window_q;
        if (shift_en_i) begin
            window_d = {window_q[WINDOW_W-SAMPLE_W-1:0], sample_i};
        end
    end

    // Window register.
    always_ff @(posedge clk) begin
        if (rst) begin
            window_q <= '0;
        end else begin
            window_q <= window_d;
        end
    end

    assign window_o = window_q;

endmodule

// File: rtl/stereo_framer.sv
// rtl/stereo_framer.sv - SYNC/L/R byte-stream framer feeding two sample windows
module stereo_framer
    import stereo_framer_pkg::*;
#(
    parameter logic [7:0] SYNC_BYTE = DEFAULT_SYNC_BYTE,
    parameter int          TIMEOUT   = 1_000_000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [7:0]  data_in,
    input  logic        data_valid,
    output logic [63:0] data_left,
    output logic [63:0] data_right,
    output logic        frame_valid,
    output logic        frame_err,
    output logic        locked
);

    localparam int GAP_W = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);
    // The gap counter times out on the idle cycle that would bring it to TIMEOUT.
    localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(TIMEOUT - 1);

    logic [1:0]       state_q, state_d;
    logic [7:0]       pend_l_q, pend_l_d;
    logic [GAP_W-1:0] gap_q, gap_d;
    logic             frame_valid_q, frame_valid_d;
    logic             frame_err_q, frame_err_d;
    logic             locked_q, locked_d;

    logic             is_sync;

    assign is_sync = (data_in == SYNC_BYTE);

    // Next-state logic: framing FSM, gap timer, pulse and lock generation.
    always_comb begin
        state_d       = state_q;
        pend_l_d      = pend_l_q;
        gap_d         = gap_q;
        frame_valid_d = 1'b0;
        frame_err_d   = 1'b0;

        case (state_q)
            ST_HUNT: begin
                gap_d = '0;
                if (data_valid && is_sync) begin
                    state_d = ST_GET_L;
                end
            end
            ST_GET_L, ST_GET_R: begin
                if (data_valid) begin
                    // A byte arriving on the timeout cycle is still accepted.
                    gap_d = '0;
                    if (is_sync) begin
                        // Unexpected sync restarts the frame.
                        frame_err_d = 1'b1;
                        pend_l_d    = '0;
                        state_d     = ST_GET_L;
                    end else if (state_q == ST_GET_L) begin
                        pend_l_d = data_in;
                        state_d  = ST_GET_R;
                    end else begin
                        frame_valid_d = 1'b1;
                        pend_l_d      = '0;
                        state_d       = ST_HUNT;
                    end
                end else if (gap_q >= GAP_LAST) begin
                    frame_err_d = 1'b1;
                    pend_l_d    = '0;
                    gap_d       = '0;
                    state_d     = ST_HUNT;
                end else begin
                    gap_d = gap_q + 1'b1;
                end
            end
            default: begin
                state_d  = ST_HUNT;
                pend_l_d = '0;
                gap_d    = '0;
            end
        endcase

        locked_d = locked_q;
        if (frame_err_d) begin
            locked_d = 1'b0;
        end else if (frame_valid_d) begin
            locked_d = 1'b1;
        end
    end

    // Control and status registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= ST_HUNT;
            pend_l_q      <= '0;
            gap_q         <= '0;
            frame_valid_q <= 1'b0;
            frame_err_q   <= 1'b0;
            locked_q      <= 1'b0;
        end else begin
            state_q       <= state_d;
            pend_l_q      <= pend_l_d;
            gap_q         <= gap_d;
            frame_valid_q <= frame_valid_d;
            frame_err_q   <= frame_err_d;
            locked_q      <= locked_d;
        end
    end

    // Both windows shift together on the R byte, so they always stay paired.
    sample_window u_win_left (
        .clk        (clk),
        .rst        (rst),
        .shift_en_i (frame_valid_d),
        .sample_i   (pend_l_q),
        .window_o   (data_left)
    );

    sample_window u_win_right (
        .clk        (clk),
        .rst        (rst),
        .shift_en_i (frame_valid_d),
        .sample_i   (data_in),
        .window_o   (data_right)
    );

    assign frame_valid = frame_valid_q;
    assign frame_err   = frame_err_q;
    assign locked      = locked_q;

endmodule

// File: tb/tb_stereo_framer.sv
// tb/tb_stereo_framer.sv - directed self-checking bench for stereo_framer
module tb_stereo_framer;

    logic        clk;
    logic        rst;
    logic [7:0]  data_in;
    logic        data_valid;
    logic [63:0] data_left;
    logic [63:0] data_right;
    logic        frame_valid;
    logic        frame_err;
    logic        locked;

    int n_checks;
    int n_errors;

    stereo_framer #(
        .SYNC_BYTE (8'hFF),
        .TIMEOUT   (16)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .data_in     (data_in),
        .data_valid  (data_valid),
        .data_left   (data_left),
        .data_right  (data_right),
        .frame_valid (frame_valid),
        .frame_err   (frame_err),
        .locked      (locked)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
        n_checks++;
        if (obs !== exp_v) begin
            n_errors++;
            $display("FAIL %s: got 0x%016h expected 0x%016h", tag, obs, exp_v);
        end
    endtask

    // Called at a falling edge; returns at the next falling edge with the
    // byte's registered effects visible.
    task automatic send_byte(input logic [7:0] b);
        data_in    = b;
        data_valid = 1'b1;
        @(negedge clk);
        data_valid = 1'b0;
        data_in    = 8'hFF;
    endtask

    task automatic idle(input int n);
        data_valid = 1'b0;
        data_in    = 8'hFF;
        repeat (n) @(negedge clk);
    endtask

    task automatic check_pulses(input string tag, input logic fv, input logic fe);
        check({tag, ".fv"}, {63'd0, frame_valid}, {63'd0, fv});
        check({tag, ".fe"}, {63'd0, frame_err}, {63'd0, fe});
    endtask

    initial begin
        n_checks   = 0;
        n_errors   = 0;
        rst        = 1'b1;
        data_in    = 8'h00;
        data_valid = 1'b0;
        repeat (3) @(negedge clk);

        check("rst.left", data_left, 64'd0);
        check("rst.right", data_right, 64'd0);
        check("rst.lock", {63'd0, locked}, 64'd0);
        check_pulses("rst", 1'b0, 1'b0);
        rst = 1'b0;
        @(negedge clk);

        // Garbage in HUNT is silently ignored.
        send_byte(8'h01); check_pulses("garb1", 1'b0, 1'b0);
        send_byte(8'h02); check_pulses("garb2", 1'b0, 1'b0);
        send_byte(8'h03); check_pulses("garb3", 1'b0, 1'b0);
        check("garb.left", data_left, 64'd0);
        check("garb.right", data_right, 64'd0);

        // First frame.
        send_byte(8'hFF); check_pulses("f1.sync", 1'b0, 1'b0);
        send_byte(8'h10); check_pulses("f1.l", 1'b0, 1'b0);
        check("f1.nopartial", data_left, 64'd0);
        send_byte(8'h20); check_pulses("f1.r", 1'b1, 1'b0);
        check("f1.left", data_left, 64'h0000_0000_0000_0010);
        check("f1.right", data_right, 64'h0000_0000_0000_0020);
        check("f1.lock", {63'd0, locked}, 64'd1);
        idle(1); check_pulses("f1.pulse_end", 1'b0, 1'b0);

        // Nine frames push the first one out of the 8-deep windows.
        for (int i = 1; i <= 9; i++) begin
            send_byte(8'hFF);
            send_byte(8'(i));
            send_byte(8'(8'h80 + i));
            check("nine.fv", {63'd0, frame_valid}, 64'd1);
        end
        check("nine.left", data_left, 64'h0203_0405_0607_0809);
        check("nine.right", data_right, 64'h8283_8485_8687_8889);

        // Sync inside a frame restarts it.
        send_byte(8'hFF);
        send_byte(8'h10);
        send_byte(8'hFF); check_pulses("resync.err", 1'b0, 1'b1);
        check("resync.lock", {63'd0, locked}, 64'd0);
        check("resync.left", data_left, 64'h0203_0405_0607_0809);
        send_byte(8'h30);
        send_byte(8'h40); check_pulses("resync.fv", 1'b1, 1'b0);
        check("resync.left2", data_left, 64'h0304_0506_0708_0930);
        check("resync.right2", data_right, 64'h8384_8586_8788_8940);
        check("resync.lock2", {63'd0, locked}, 64'd1);

        // Timeout after 16 idle cycles in GET_R.
        send_byte(8'hFF);
        send_byte(8'h10);
        idle(15); check_pulses("to.before", 1'b0, 1'b0);
        idle(1);  check_pulses("to.hit", 1'b0, 1'b1);
        check("to.lock", {63'd0, locked}, 64'd0);
        send_byte(8'h50); check_pulses("to.hunt", 1'b0, 1'b0);
        send_byte(8'hFF);
        send_byte(8'h01);
        send_byte(8'h02); check_pulses("to.fv", 1'b1, 1'b0);
        check("to.left", data_left, 64'h0405_0607_0809_3001);
        check("to.right", data_right, 64'h8485_8687_8889_4002);

        // Byte on the timeout cycle wins.
        send_byte(8'hFF);
        send_byte(8'h10);
        idle(15);
        send_byte(8'h20); check_pulses("race", 1'b1, 1'b0);
        check("race.left", data_left, 64'h0506_0708_0930_0110);
        check("race.right", data_right, 64'h8586_8788_8940_0220);

        // Timeout while waiting for L.
        send_byte(8'hFF);
        idle(15); check_pulses("tol.before", 1'b0, 1'b0);
        idle(1);  check_pulses("tol.hit", 1'b0, 1'b1);

        // Reset in GET_R overrides a concurrent byte.
        send_byte(8'hFF);
        send_byte(8'h11);
        rst        = 1'b1;
        data_in    = 8'h77;
        data_valid = 1'b1;
        @(negedge clk);
        rst        = 1'b0;
        data_valid = 1'b0;
        check_pulses("rstr", 1'b0, 1'b0);
        check("rstr.left", data_left, 64'd0);
        check("rstr.right", data_right, 64'd0);
        send_byte(8'h77); check_pulses("rstr.after", 1'b0, 1'b0);
        check("rstr.left2", data_left, 64'd0);
        check("rstr.right2", data_right, 64'd0);
        check("rstr.lock", {63'd0, locked}, 64'd0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
